// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq
//  Description : Reset sequencer. Asserts every domain reset asynchronously,
//                synchronizes the release of the raw board reset, waits a hold
//                period, then releases the domains in order with a fixed gap.
//                A software request restarts the hold/release sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int NUM_DOMAINS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] rst_n_o,
  output logic                   done_o,
  output logic [7:0]             sw_rst_cnt_o
);

  localparam int c_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int c_GAP_W  = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;

  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [c_GAP_W-1:0]  c_GAP_LAST  = c_GAP_W'(GAP_CYCLES - 1);

  localparam logic [1:0] c_SYNC    = 2'd0;
  localparam logic [1:0] c_HOLD    = 2'd1;
  localparam logic [1:0] c_RELEASE = 2'd2;
  localparam logic [1:0] c_DONE    = 2'd3;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [c_HOLD_W-1:0]    r_hold_cnt;
  logic [c_GAP_W-1:0]     r_gap_cnt;
  logic [NUM_DOMAINS-1:0] r_rst_n;
  logic                   r_done;
  logic [7:0]             r_sw_cnt;

  logic [1:0]             w_state_nxt;
  logic [c_HOLD_W-1:0]    w_hold_cnt_nxt;
  logic [c_GAP_W-1:0]     w_gap_cnt_nxt;
  logic [NUM_DOMAINS-1:0] w_rst_n_nxt;
  logic                   w_done_nxt;
  logic                   w_sw_acc;
  logic [NUM_DOMAINS-1:0] w_rel_thermo;
  logic                   w_rel_last;
  logic                   w_hold_end;
  logic                   w_gap_end;

  // Domains are released strictly in order, so the release vector is a
  // thermometer code: releasing the next domain is a shift-in of a one.
  assign w_rel_thermo = NUM_DOMAINS'({r_rst_n, 1'b1});
  assign w_rel_last   = &w_rel_thermo;
  assign w_hold_end   = (r_state == c_HOLD)    && (r_hold_cnt == c_HOLD_LAST);
  assign w_gap_end    = (r_state == c_RELEASE) && (r_gap_cnt  == c_GAP_LAST);
  assign w_sw_acc     = sw_rst_req_i && (r_state != c_SYNC);

  // State, counters, synchronizer and registered outputs; raw reset clears all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync     <= '0;
      r_state    <= c_SYNC;
      r_hold_cnt <= '0;
      r_gap_cnt  <= '0;
      r_rst_n    <= '0;
      r_done     <= 1'b0;
      r_sw_cnt   <= 8'd0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], 1'b1};
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_rst_n    <= w_rst_n_nxt;
      r_done     <= w_done_nxt;
      if (w_sw_acc && (r_sw_cnt != 8'hFF)) begin
        r_sw_cnt <= r_sw_cnt + 8'd1;
      end
    end
  end

  // Next-state and counter sequencing; an accepted software request restarts HOLD.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    case (r_state)
      c_SYNC: begin
        if (r_sync[SYNC_STAGES-1]) begin
          w_state_nxt    = c_HOLD;
          w_hold_cnt_nxt = '0;
        end
      end
      c_HOLD: begin
        if (w_hold_end) begin
          w_state_nxt   = (NUM_DOMAINS == 1) ? c_DONE : c_RELEASE;
          w_gap_cnt_nxt = '0;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      c_RELEASE: begin
        if (w_gap_end) begin
          w_gap_cnt_nxt = '0;
          if (w_rel_last) begin
            w_state_nxt = c_DONE;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = c_DONE;
      end
    endcase
    if (w_sw_acc) begin
      w_state_nxt    = c_HOLD;
      w_hold_cnt_nxt = '0;
      w_gap_cnt_nxt  = '0;
    end
  end

  // Next values of the registered reset lines and done flag.
  always_comb begin
    w_rst_n_nxt = r_rst_n;
    w_done_nxt  = r_done;
    if (w_hold_end || w_gap_end) begin
      w_rst_n_nxt = w_rel_thermo;
      w_done_nxt  = w_rel_last;
    end
    if (w_sw_acc) begin
      w_rst_n_nxt = '0;
      w_done_nxt  = 1'b0;
    end
  end

  assign rst_n_o      = r_rst_n;
  assign done_o       = r_done;
  assign sw_rst_cnt_o = r_sw_cnt;

endmodule
`default_nettype wire
